// File: rtl/ofifo_drain_ctrl.sv
// Drains num_rows rows from the output FIFO bank into consecutive PSUM SRAM
// addresses starting at base_addr, one row per granted cycle, then pulses done.
module ofifo_drain_ctrl #(
  parameter int cols    = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [addr_bw-1:0]        base_addr,
  input  logic [addr_bw-1:0]        num_rows,
  input  logic                      rd_ready,
  input  logic [cols*psum_bw-1:0]   fifo_out,
  input  logic                      sram_gnt,
  output logic                      rd,
  output logic                      sram_cen,
  output logic                      sram_wen,
  output logic [addr_bw-1:0]        sram_addr,
  output logic [cols*psum_bw-1:0]   sram_d,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  state_t             state_reg, state_next;
  logic [addr_bw-1:0] base_reg;
  logic [addr_bw-1:0] num_reg;
  logic [addr_bw-1:0] issued_reg;
  logic [addr_bw-1:0] written_reg;
  logic [addr_bw-1:0] written_next;
  logic [psum_bw-1:0] sram_d_reg [cols];

  always_comb begin
    state_next = state_reg;
    rd         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (num_rows == '0) ? DONE : DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        rd   = rd_ready & sram_gnt & (issued_reg < num_reg);
        if (rd && (issued_reg + addr_bw'(1) == num_reg)) state_next = FLUSH;
      end
      FLUSH: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A write presented this cycle is not yet counted in written_reg.
  assign written_next = written_reg + addr_bw'(!sram_cen);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      base_reg    <= '0;
      num_reg     <= '0;
      issued_reg  <= '0;
      written_reg <= '0;
      sram_cen    <= 1'b1;
      sram_wen    <= 1'b1;
      sram_addr   <= '0;
    end else begin
      state_reg <= state_next;
      sram_cen  <= ~rd;
      sram_wen  <= ~rd;
      if (state_reg == IDLE && start) begin
        base_reg    <= base_addr;
        num_reg     <= num_rows;
        issued_reg  <= '0;
        written_reg <= '0;
      end else begin
        written_reg <= written_next;
        if (rd) begin
          issued_reg <= issued_reg + addr_bw'(1);
          sram_addr  <= base_reg + written_next;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < cols; gi++) begin : g_col
      always_ff @(posedge clk or posedge reset) begin
        if (reset)   sram_d_reg[gi] <= '0;
        else if (rd) sram_d_reg[gi] <= fifo_out[gi*psum_bw +: psum_bw];
      end
      assign sram_d[gi*psum_bw +: psum_bw] = sram_d_reg[gi];
    end
  endgenerate

endmodule
